onehot_lock_mux: RTL and testbench

Registered, packet-locking one-hot multiplexer for the VC-based mesh router output stage. Selects one of SEL_WIDTH flit lanes with a one-hot grant, holds that selection from head flit to tail flit, and presents the result through a one-entry valid/ready output register. It sits between the switch-allocator grant and the output-port link register and replaces purely combinational lane selection where back-pressure and wormhole locking are needed.

---
 rtl/onehot_lock_mux_pkg.sv | 23 ++
 rtl/onehot_lock_mux_andor_sel.sv | 19 +
 rtl/onehot_lock_mux.sv | 142 ++++++++++++++
 tb/tb_onehot_lock_mux.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_lock_mux_pkg.sv
// Shared types and helpers for the packet-locking one-hot output mux.
package onehot_lock_mux_pkg;

  // Widest select vector the one-hot helpers accept.
  localparam int MAX_SEL_WIDTH = 32;

  // Lock FSM: IDLE samples the allocator grant, LOCKED holds it until a tail.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [MAX_SEL_WIDTH-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // True when two or more bits of v are set.
  function automatic logic is_multihot(input logic [MAX_SEL_WIDTH-1:0] v);
    return (v != '0) && !is_onehot(v);
  endfunction

endpackage

// File: rtl/onehot_lock_mux_andor_sel.sv
// Combinational AND-OR lane selector; yields zero when the select is zero.
module onehot_andor_sel #(
  parameter int WIDTH     = 32,
  parameter int SEL_WIDTH = 5
) (
  input  logic [SEL_WIDTH*WIDTH-1:0] lanes,
  input  logic [SEL_WIDTH-1:0]       sel,
  output logic [WIDTH-1:0]           out
);

  // OR together every lane gated by its own select bit.
  always_comb begin
    out = '0;
    for (int i = 0; i < SEL_WIDTH; i++) begin
      out = out | (lanes[i*WIDTH +: WIDTH] & {WIDTH{sel[i]}});
    end
  end

endmodule

// File: rtl/onehot_lock_mux.sv
// Packet-locking one-hot mux with a one-entry registered output stage.
//
// Handshake: a lane flit moves when in_valid[i] && in_ready[i] on a rising
// edge; in_ready never looks at in_valid. The output flit moves downstream
// when out_valid && out_ready. The output register accepts a new flit when it
// is empty or being drained in the same cycle, so full throughput needs no
// bubble. The FSM state is visible on the locked output.
module onehot_lock_mux
  import onehot_lock_mux_pkg::*;
#(
  parameter int FLIT_WIDTH = 32,
  parameter int SEL_WIDTH  = 5
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [SEL_WIDTH*FLIT_WIDTH-1:0] mux_in,
  input  logic [SEL_WIDTH-1:0]            in_valid,
  input  logic [SEL_WIDTH-1:0]            in_tail,
  input  logic [SEL_WIDTH-1:0]            sel,
  output logic [SEL_WIDTH-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]           mux_out,
  output logic                            out_tail,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            locked,
  output logic                            sel_err
);

  state_t                 state, next_state;
  logic [SEL_WIDTH-1:0]   lock_sel, next_lock_sel;
  logic [SEL_WIDTH-1:0]   eff_sel;
  logic [FLIT_WIDTH-1:0]  sel_data;
  logic                   sel_tail;
  logic                   can_accept;
  logic                   sel_onehot;
  logic                   sel_multihot;
  logic                   xfer;

  assign sel_onehot   = is_onehot(MAX_SEL_WIDTH'(sel));
  assign sel_multihot = is_multihot(MAX_SEL_WIDTH'(sel));
  assign can_accept   = !out_valid || out_ready;

  // Effective select: live grant in IDLE (only if cleanly one-hot), held lock otherwise.
  always_comb begin
    eff_sel = '0;
    if (state == ST_LOCKED) begin
      eff_sel = lock_sel;
    end else if (sel_onehot) begin
      eff_sel = sel;
    end
  end

  // Pop toward the selected lane only when the output register can take a flit.
  always_comb begin
    in_ready = '0;
    if (!reset) begin
      in_ready = eff_sel & {SEL_WIDTH{can_accept}};
    end
  end

  assign xfer = |(in_valid & in_ready);

  onehot_andor_sel #(
    .WIDTH     (FLIT_WIDTH),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_data_sel (
    .lanes (mux_in),
    .sel   (eff_sel),
    .out   (sel_data)
  );

  onehot_andor_sel #(
    .WIDTH     (1),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_tail_sel (
    .lanes (in_tail),
    .sel   (eff_sel),
    .out   (sel_tail)
  );

  // Lock on a non-tail transfer in IDLE, release on a tail transfer in LOCKED.
  always_comb begin
    next_state    = state;
    next_lock_sel = lock_sel;
    case (state)
      ST_IDLE: begin
        if (xfer && !sel_tail) begin
          next_state    = ST_LOCKED;
          next_lock_sel = sel;
        end
      end
      ST_LOCKED: begin
        if (xfer && sel_tail) begin
          next_state    = ST_IDLE;
          next_lock_sel = '0;
        end
      end
      default: begin
        next_state    = ST_IDLE;
        next_lock_sel = '0;
      end
    endcase
  end

  // FSM state and held grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      lock_sel <= '0;
    end else begin
      state    <= next_state;
      lock_sel <= next_lock_sel;
    end
  end

  // Output register: load on transfer, empty on drain, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mux_out   <= '0;
      out_tail  <= 1'b0;
      out_valid <= 1'b0;
    end else if (xfer) begin
      mux_out   <= sel_data;
      out_tail  <= sel_tail;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // One-cycle error pulse for a multi-hot grant seen while IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= (state == ST_IDLE) && sel_multihot;
    end
  end

  assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_onehot_lock_mux.sv
// Bench for onehot_lock_mux: directed vector table, reset corner cases and a
// randomized run against a lane-index reference model with a flit scoreboard.
module tb_onehot_lock_mux;

  localparam int FW = 32;
  localparam int SW = 5;

  logic              clk;
  logic              reset;
  logic [SW*FW-1:0]  mux_in;
  logic [SW-1:0]     in_valid;
  logic [SW-1:0]     in_tail;
  logic [SW-1:0]     sel;
  logic [SW-1:0]     in_ready;
  logic [FW-1:0]     mux_out;
  logic              out_tail;
  logic              out_valid;
  logic              out_ready;
  logic              locked;
  logic              sel_err;

  int checks = 0;
  int errors = 0;

  logic [FW-1:0] exp_q[$];

  onehot_lock_mux #(.FLIT_WIDTH(FW), .SEL_WIDTH(SW)) dut (
    .clk       (clk),
    .reset     (reset),
    .mux_in    (mux_in),
    .in_valid  (in_valid),
    .in_tail   (in_tail),
    .sel       (sel),
    .in_ready  (in_ready),
    .mux_out   (mux_out),
    .out_tail  (out_tail),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .locked    (locked),
    .sel_err   (sel_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [SW*FW-1:0] build_bus(input int dl, input logic [FW-1:0] dat);
    logic [SW*FW-1:0] b;
    for (int i = 0; i < SW; i++) begin
      b[i*FW +: FW] = (i == dl) ? dat : (32'hDEAD_0000 | 32'(i));
    end
    return b;
  endfunction

  task automatic drive(input logic [SW-1:0] s, input logic [SW-1:0] v,
                       input logic [SW-1:0] t, input logic [SW*FW-1:0] bus,
                       input logic ordy);
    sel       = s;
    in_valid  = v;
    in_tail   = t;
    mux_in    = bus;
    out_ready = ordy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [SW-1:0] sel;
    logic [SW-1:0] vld;
    logic [SW-1:0] tl;
    int            dl;
    logic [FW-1:0] dat;
    logic          ordy;
    logic [SW-1:0] e_rdy;
    logic          e_ov;
    logic [FW-1:0] e_out;
    logic          e_tail;
    logic          e_lk;
    logic          e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [SW-1:0] s, input logic [SW-1:0] v, input logic [SW-1:0] t,
                         input int dl, input logic [FW-1:0] dat, input logic ordy,
                         input logic [SW-1:0] e_rdy, input logic e_ov, input logic [FW-1:0] e_out,
                         input logic e_tail, input logic e_lk, input logic e_err);
    vec_t r;
    r.sel = s; r.vld = v; r.tl = t; r.dl = dl; r.dat = dat; r.ordy = ordy;
    r.e_rdy = e_rdy; r.e_ov = e_ov; r.e_out = e_out; r.e_tail = e_tail;
    r.e_lk = e_lk; r.e_err = e_err;
    vecs.push_back(r);
  endtask

  // ---------------- reference model state ----------------
  int            m_lock;   // locked lane index, -1 when free
  logic          m_valid;
  logic [FW-1:0] m_data;
  logic          m_tail;
  logic          m_err;

  initial begin
    logic [SW-1:0] r_sel, r_vld, r_tl;
    logic [SW*FW-1:0] r_bus;
    logic r_ordy;
    int lane, cnt, pick;
    logic can, xfer;
    logic [SW-1:0] e_rdy;
    logic [FW-1:0] front;

    // reset: outputs cleared and no pop while reset is high
    reset = 1'b1;
    drive(5'b00001, 5'b00001, 5'b00000, build_bus(0, 32'h1), 1'b1);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_mux_out", mux_out, 32'h0);
    chk("rst_out_tail", 32'(out_tail), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_sel_err", 32'(sel_err), 32'h0);
    drive('0, '0, '0, build_bus(-1, 32'h0), 1'b1);
    reset = 1'b0;
    next_cycle();

    // single flit packet on lane 2
    add_vec(5'b00100, 5'b00100, 5'b00100, 2, 32'hA5A5_0001, 1, 5'b00100, 1, 32'hA5A5_0001, 1, 0, 0);
    add_vec(5'b00000, 5'b00000, 5'b00000, 0, 32'h0,         1, 5'b00000, 0, 32'hA5A5_0001, 1, 0, 0);
    // lane 1 three-flit packet, grant moves away after the head
    add_vec(5'b00010, 5'b00010, 5'b00000, 1, 32'h11, 1, 5'b00010, 1, 32'h11, 0, 1, 0);
    add_vec(5'b01000, 5'b01010, 5'b00000, 1, 32'h12, 1, 5'b00010, 1, 32'h12, 0, 1, 0);
    add_vec(5'b01000, 5'b01010, 5'b00010, 1, 32'h13, 1, 5'b00010, 1, 32'h13, 1, 0, 0);
    add_vec(5'b00000, 5'b00000, 5'b00000, 0, 32'h0,  1, 5'b00000, 0, 32'h13, 1, 0, 0);
    // stall four cycles mid-packet on lane 0
    add_vec(5'b00001, 5'b00001, 5'b00000, 0, 32'h21, 1, 5'b00001, 1, 32'h21, 0, 1, 0);
    for (int k = 0; k < 4; k++)
      add_vec(5'b00001, 5'b00001, 5'b00000, 0, 32'h22, 0, 5'b00000, 1, 32'h21, 0, 1, 0);
    add_vec(5'b00001, 5'b00001, 5'b00000, 0, 32'h22, 1, 5'b00001, 1, 32'h22, 0, 1, 0);
    add_vec(5'b00001, 5'b00001, 5'b00001, 0, 32'h23, 1, 5'b00001, 1, 32'h23, 1, 0, 0);
    add_vec(5'b00000, 5'b00000, 5'b00000, 0, 32'h0,  1, 5'b00000, 0, 32'h23, 1, 0, 0);
    // multi-hot grant then a clean one
    add_vec(5'b00110, 5'b00110, 5'b00110, 1, 32'h31, 1, 5'b00000, 0, 32'h23, 1, 0, 1);
    add_vec(5'b00010, 5'b00010, 5'b00010, 1, 32'h32, 1, 5'b00010, 1, 32'h32, 1, 0, 0);
    // lane 4 valid toggling 1,0,1 while locked
    add_vec(5'b10000, 5'b10000, 5'b00000, 4, 32'h41, 1, 5'b10000, 1, 32'h41, 0, 1, 0);
    add_vec(5'b00000, 5'b00000, 5'b00000, 4, 32'h0,  1, 5'b10000, 0, 32'h41, 0, 1, 0);
    add_vec(5'b00000, 5'b10000, 5'b10000, 4, 32'h42, 1, 5'b10000, 1, 32'h42, 1, 0, 0);
    add_vec(5'b00000, 5'b00000, 5'b00000, 0, 32'h0,  1, 5'b00000, 0, 32'h42, 1, 0, 0);

    foreach (vecs[n]) begin
      drive(vecs[n].sel, vecs[n].vld, vecs[n].tl, build_bus(vecs[n].dl, vecs[n].dat), vecs[n].ordy);
      #1;
      chk($sformatf("vec%0d_in_ready", n), 32'(in_ready), 32'(vecs[n].e_rdy));
      next_cycle();
      chk($sformatf("vec%0d_out_valid", n), 32'(out_valid), 32'(vecs[n].e_ov));
      chk($sformatf("vec%0d_mux_out", n), mux_out, vecs[n].e_out);
      chk($sformatf("vec%0d_out_tail", n), 32'(out_tail), 32'(vecs[n].e_tail));
      chk($sformatf("vec%0d_locked", n), 32'(locked), 32'(vecs[n].e_lk));
      chk($sformatf("vec%0d_sel_err", n), 32'(sel_err), 32'(vecs[n].e_err));
    end

    // reset while locked with a buffered flit
    drive(5'b00001, 5'b00001, 5'b00000, build_bus(0, 32'h51), 1'b1);
    next_cycle();
    chk("mid_pre_locked", 32'(locked), 32'h1);
    drive(5'b00001, 5'b00001, 5'b00000, build_bus(0, 32'h52), 1'b0);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_locked", 32'(locked), 32'h0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
    next_cycle();
    reset = 1'b0;
    drive(5'b00001, 5'b00001, 5'b00000, build_bus(0, 32'h61), 1'b1);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);
    next_cycle();
    chk("post_rst_mux_out", mux_out, 32'h61);
    chk("post_rst_locked", 32'(locked), 32'h1);
    drive(5'b00001, 5'b00001, 5'b00001, build_bus(0, 32'h62), 1'b1);
    next_cycle();
    chk("post_rst_tail_unlock", 32'(locked), 32'h0);

    // randomized run against the reference model
    drive('0, '0, '0, build_bus(-1, 32'h0), 1'b1);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    m_lock = -1; m_valid = 0; m_data = '0; m_tail = 0; m_err = 0;
    exp_q.delete();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      pick = $urandom_range(0, 9);
      if (pick < 5)      r_sel = 5'(1 << $urandom_range(0, SW-1));
      else if (pick < 7) r_sel = '0;
      else               r_sel = 5'($urandom);
      r_vld  = 5'($urandom);
      r_tl   = '0;
      for (int i = 0; i < SW; i++) begin
        r_tl[i] = ($urandom_range(0, 9) < 3);
        r_bus[i*FW +: FW] = $urandom;
      end
      r_ordy = ($urandom_range(0, 3) != 0);
      drive(r_sel, r_vld, r_tl, r_bus, r_ordy);
      #1;

      // which lane the grant points at this cycle
      cnt = $countones(r_sel);
      lane = -1;
      if (m_lock >= 0) lane = m_lock;
      else if (cnt == 1) begin
        for (int i = 0; i < SW; i++) if (r_sel[i]) lane = i;
      end
      can   = !m_valid || r_ordy;
      e_rdy = (lane >= 0 && can) ? 5'(1 << lane) : '0;
      chk("rnd_in_ready", 32'(in_ready), 32'(e_rdy));
      xfer = (lane >= 0) && can && r_vld[lane];

      // scoreboard: the flit leaving now must be the oldest accepted one
      if (out_valid && r_ordy) begin
        if (exp_q.size() == 0) chk("rnd_sb_empty", 32'h1, 32'h0);
        else begin
          front = exp_q.pop_front();
          chk("rnd_sb_order", mux_out, front);
        end
      end

      m_err = (m_lock < 0) && (cnt > 1);
      if (xfer) begin
        m_data  = r_bus[lane*FW +: FW];
        m_tail  = r_tl[lane];
        m_valid = 1'b1;
        exp_q.push_back(m_data);
        if (m_lock < 0 && !m_tail) m_lock = lane;
        else if (m_lock >= 0 && m_tail) m_lock = -1;
      end else if (r_ordy) begin
        m_valid = 1'b0;
      end

      next_cycle();
      chk("rnd_out_valid", 32'(out_valid), 32'(m_valid));
      chk("rnd_mux_out", mux_out, m_data);
      chk("rnd_out_tail", 32'(out_tail), 32'(m_tail));
      chk("rnd_locked", 32'(locked), 32'(m_lock >= 0));
      chk("rnd_sel_err", 32'(sel_err), 32'(m_err));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
